// File: rtl/bpm_display_mux.sv
// Four-digit multiplexed seven-segment driver for the bpm readout: frame-synchronous digit capture,
// leading-zero blanking and stale dashes. Optional beat flash on the status slot with PM_BEAT_FLASH_EN.
module bpm_display_mux #(
    parameter int REFRESH_DIV = 100000,
    parameter int TIMEOUT_CYC = 300000000,
    parameter int FLASH_CYC   = 10000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] d2,
    input  logic [3:0] d1,
    input  logic [3:0] d0,
    input  logic       beat,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [TW-1:0] TO_MAX     = TW'(TIMEOUT_CYC);
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
        logic [6:0] p;
        case (v)
            4'd0:    p = 7'b1000000;
            4'd1:    p = 7'b1111001;
            4'd2:    p = 7'b0100100;
            4'd3:    p = 7'b0110000;
            4'd4:    p = 7'b0011001;
            4'd5:    p = 7'b0010010;
            4'd6:    p = 7'b0000010;
            4'd7:    p = 7'b1111000;
            4'd8:    p = 7'b0000000;
            4'd9:    p = 7'b0010000;
            default: p = 7'b0000110;
        endcase
        return p;
    endfunction

    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    s2_q, s1_q, s0_q, s2_d, s1_d, s0_d;
    logic [TW-1:0] to_q, to_d;
    logic          stale_q, stale_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic          tick_s;
    logic [3:0]    s3_an_s;
    logic          s3_dp_s;

    // Slot prescaler, scan index and frame-wrap shadow capture.
    always_comb begin
        tick_s  = (presc_q == PRESC_LAST);
        presc_d = tick_s ? {PW{1'b0}} : presc_q + PW'(1);
        idx_d   = tick_s ? idx_q + 2'd1 : idx_q;
        if (tick_s && (idx_q == 2'd3)) begin
            s2_d = d2;
            s1_d = d1;
            s0_d = d0;
        end else begin
            s2_d = s2_q;
            s1_d = s1_q;
            s0_d = s0_q;
        end
    end

    // Beat timeout: saturating counter, a beat always wins over the saturation edge.
    always_comb begin
        if (beat) begin
            to_d    = {TW{1'b0}};
            stale_d = 1'b0;
        end else if (to_q == TO_MAX) begin
            to_d    = to_q;
            stale_d = 1'b1;
        end else begin
            to_d    = to_q + TW'(1);
            stale_d = stale_q | ((to_q + TW'(1)) == TO_MAX);
        end
    end

`ifdef PM_BEAT_FLASH_EN
    localparam int FW = $clog2(FLASH_CYC + 1);
    logic [FW-1:0] flash_q, flash_d;

    // Beat flash down-counter; the status slot follows its next value.
    always_comb begin
        if (beat) begin
            flash_d = FW'(FLASH_CYC);
        end else if (flash_q != {FW{1'b0}}) begin
            flash_d = flash_q - FW'(1);
        end else begin
            flash_d = flash_q;
        end
        s3_an_s = (flash_d != {FW{1'b0}}) ? 4'b0111 : 4'b1111;
        s3_dp_s = (flash_d == {FW{1'b0}});
    end

    // Flash counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flash_q <= {FW{1'b0}};
        end else begin
            flash_q <= flash_d;
        end
    end
`else
    // Status slot stays dark so every slot keeps the same duty cycle.
    always_comb begin
        s3_an_s = 4'b1111;
        s3_dp_s = 1'b1;
    end
`endif

    // Next display word: digit slots change only on a slot boundary, the status slot may update any cycle.
    always_comb begin
        an_d  = an_q;
        seg_d = seg_q;
        dp_d  = dp_q;
        if (tick_s) begin
            case (idx_d)
                2'd0: begin
                    an_d  = 4'b1110;
                    seg_d = stale_q ? SEG_DASH : bcd_to_seg(s0_d);
                    dp_d  = 1'b1;
                end
                2'd1: begin
                    an_d  = 4'b1101;
                    seg_d = stale_q ? SEG_DASH :
                            ((s2_d == 4'd0) && (s1_d == 4'd0)) ? SEG_BLANK : bcd_to_seg(s1_d);
                    dp_d  = 1'b1;
                end
                2'd2: begin
                    an_d  = 4'b1011;
                    seg_d = stale_q ? SEG_DASH : (s2_d == 4'd0) ? SEG_BLANK : bcd_to_seg(s2_d);
                    dp_d  = 1'b1;
                end
                2'd3: begin
                    an_d  = s3_an_s;
                    seg_d = SEG_BLANK;
                    dp_d  = s3_dp_s;
                end
                default: begin
                    an_d  = 4'b1111;
                    seg_d = SEG_BLANK;
                    dp_d  = 1'b1;
                end
            endcase
        end else if (idx_q == 2'd3) begin
            an_d  = s3_an_s;
            seg_d = SEG_BLANK;
            dp_d  = s3_dp_s;
        end else begin
            an_d  = an_q;
            seg_d = seg_q;
            dp_d  = dp_q;
        end
    end

    // State and output registers; reset blanks the display immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q <= {PW{1'b0}};
            idx_q   <= 2'd0;
            s2_q    <= 4'd0;
            s1_q    <= 4'd0;
            s0_q    <= 4'd0;
            to_q    <= {TW{1'b0}};
            stale_q <= 1'b1;
            an_q    <= 4'b1111;
            seg_q   <= SEG_BLANK;
            dp_q    <= 1'b1;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            s2_q    <= s2_d;
            s1_q    <= s1_d;
            s0_q    <= s0_d;
            to_q    <= to_d;
            stale_q <= stale_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_bpm_display_mux.sv
// Self-checking bench for bpm_display_mux: directed scenarios plus random beats/digits/resets,
// compared every cycle against a frame-level model of the display.
module tb_bpm_display_mux;

    localparam int RD = 4;
    localparam int TO = 50;
    localparam int FL = 8;
    localparam logic [6:0] DASH  = 7'b0111111;
    localparam logic [6:0] BLANK = 7'b1111111;

    logic       clk = 1'b0;
    logic       rst;
    logic       beat;
    logic [3:0] d2, d1, d0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int total = 0;
    int bad   = 0;

    // model state
    int         m_cyc, m_since, m_flash, m_ns;
    bit         m_stale, m_tick;
    int         m_sh [3];
    logic [3:0] m_an;
    logic [6:0] m_seg;
    logic       m_dp;
    logic [3:0] cd2, cd1, cd0;

    logic [6:0] digit_pat [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                   7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    bpm_display_mux #(.REFRESH_DIV(RD), .TIMEOUT_CYC(TO), .FLASH_CYC(FL)) dut (
        .clk(clk), .rst(rst), .d2(d2), .d1(d1), .d0(d0), .beat(beat),
        .an(an), .seg(seg), .dp(dp)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input int v);
        if (v > 9) return 7'b0000110;
        return digit_pat[v];
    endfunction

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: an/seg/dp got %b_%b_%b expected %b_%b_%b", name, $time,
                     act[11:8], act[7:1], act[0], exp[11:8], exp[7:1], exp[0]);
        end
    endtask

    task automatic model_reset();
        m_cyc = 0; m_since = 0; m_stale = 1'b1; m_flash = 0; m_ns = 0; m_tick = 1'b0;
        for (int i = 0; i < 3; i++) m_sh[i] = 0;
        m_an = 4'b1111; m_seg = BLANK; m_dp = 1'b1;
    endtask

    // Advance the model across one rising edge using the inputs currently driven.
    task automatic model_step();
        int ns;
        int fnext;
        m_tick = ((m_cyc % RD) == RD - 1);
        ns     = ((m_cyc + 1) / RD) % 4;
        fnext  = beat ? FL : ((m_flash > 0) ? m_flash - 1 : 0);
        if (m_tick && ns == 0) begin
            m_sh[0] = int'(d0); m_sh[1] = int'(d1); m_sh[2] = int'(d2);
        end
        if (m_tick && ns < 3) begin
            m_an = 4'b1111;
            m_an[ns] = 1'b0;
            m_dp = 1'b1;
            if (m_stale) m_seg = DASH;
            else if ((ns == 2 && m_sh[2] == 0) || (ns == 1 && m_sh[2] == 0 && m_sh[1] == 0)) m_seg = BLANK;
            else m_seg = seg_of(m_sh[ns]);
        end else if (ns == 3) begin
`ifdef PM_BEAT_FLASH_EN
            m_an = (fnext > 0) ? 4'b0111 : 4'b1111;
            m_seg = BLANK;
            m_dp = (fnext == 0);
`else
            m_an = 4'b1111; m_seg = BLANK; m_dp = 1'b1;
`endif
        end
        m_ns = ns;
        m_flash = fnext;
        if (beat) begin
            m_since = 0; m_stale = 1'b0;
        end else begin
            if (m_since < TO) m_since++;
            if (m_since >= TO) m_stale = 1'b1;
        end
        m_cyc++;
    endtask

    // Called just after a falling edge: drive, step the model, then compare at the next falling edge.
    task automatic cycle(input bit b, input logic [3:0] a2, input logic [3:0] a1, input logic [3:0] a0);
        beat = b; d2 = a2; d1 = a1; d0 = a0;
        if (!rst) model_reset();
        else model_step();
        @(negedge clk);
        check("cycle", {an, seg, dp}, {m_an, m_seg, m_dp});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, cd2, cd1, cd0);
    endtask

    task automatic run_to_slot(input int s);
        bit found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            cycle(1'b0, cd2, cd1, cd0);
            if (m_tick && m_ns == s) found = 1'b1;
        end
        if (!found) begin
            total++; bad++;
            $display("FAIL slot_wait: slot %0d not reached within 40 cycles", s);
        end
    endtask

    task automatic lit(input string name, input logic [3:0] ea, input logic [6:0] es, input logic ed);
        check(name, {an, seg, dp}, {ea, es, ed});
    endtask

    initial begin
        rst = 1'b0; beat = 1'b0; d2 = 4'd0; d1 = 4'd0; d0 = 4'd0;
        cd2 = 4'd0; cd1 = 4'd0; cd0 = 4'd0;
        model_reset();
        repeat (3) @(negedge clk);
        lit("reset_state", 4'b1111, BLANK, 1'b1);
        rst = 1'b1;

        // dashes until the first beat, status slot dark
        run_to_slot(1); lit("s1_dash", 4'b1101, DASH, 1'b1);
        run_to_slot(2); lit("s2_dash", 4'b1011, DASH, 1'b1);
        run_to_slot(3); lit("s3_dark", 4'b1111, BLANK, 1'b1);
        run_to_slot(0); lit("s0_dash", 4'b1110, DASH, 1'b1);

        // bpm 120
        cd2 = 4'd1; cd1 = 4'd2; cd0 = 4'd0;
        cycle(1'b1, cd2, cd1, cd0);
        run_to_slot(0); lit("120_s0", 4'b1110, 7'b1000000, 1'b1);
        run_to_slot(1); lit("120_s1", 4'b1101, 7'b0100100, 1'b1);
        run_to_slot(2); lit("120_s2", 4'b1011, 7'b1111001, 1'b1);

        // bpm 7 with leading-zero blanking
        cd2 = 4'd0; cd1 = 4'd0; cd0 = 4'd7;
        cycle(1'b1, cd2, cd1, cd0);
        run_to_slot(0); lit("007_s0", 4'b1110, 7'b1111000, 1'b1);
        run_to_slot(1); lit("007_s1_blank", 4'b1101, BLANK, 1'b1);
        run_to_slot(2); lit("007_s2_blank", 4'b1011, BLANK, 1'b1);

        // timeout to stale, then beat exactly on the saturating edge
        cycle(1'b1, cd2, cd1, cd0);
        idle(TO);
        run_to_slot(0); lit("stale_dash", 4'b1110, DASH, 1'b1);
        cycle(1'b1, cd2, cd1, cd0);
        idle(TO - 1);
        cycle(1'b1, cd2, cd1, cd0);
        run_to_slot(0); lit("beat_wins", 4'b1110, 7'b1111000, 1'b1);

        // input change mid-frame is deferred to the wrap
        cycle(1'b1, cd2, cd1, cd0);
        run_to_slot(1);
        cd0 = 4'd5;
        run_to_slot(0); lit("d0_5", 4'b1110, 7'b0010010, 1'b1);
        cd0 = 4'd12;
        cycle(1'b1, cd2, cd1, cd0);
        run_to_slot(0); lit("d0_E", 4'b1110, 7'b0000110, 1'b1);

`ifdef PM_BEAT_FLASH_EN
        run_to_slot(3);
        cycle(1'b1, cd2, cd1, cd0);
        lit("flash_on", 4'b0111, BLANK, 1'b0);
        run_to_slot(3); lit("flash_off", 4'b1111, BLANK, 1'b1);
`endif

        // asynchronous reset in the middle of slot 2
        cycle(1'b1, cd2, cd1, cd0);
        run_to_slot(2);
        cycle(1'b0, cd2, cd1, cd0);
        #2;
        rst = 1'b0;
        #1;
        lit("async_rst", 4'b1111, BLANK, 1'b1);
        @(negedge clk);
        cycle(1'b0, cd2, cd1, cd0);
        rst = 1'b1;

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                cd2 = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
                cd1 = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
                cd0 = 4'($urandom_range(0, 15));
            end
            rst = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
            cycle($urandom_range(0, 59) == 0, cd2, cd1, cd0);
        end
        rst = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bpm_display_mux.md
Name: bpm_display_mux

Overview:
- Downstream of the pulse monitor datapath. Consumes the BCD bpm digits (d2 = hundreds, d1 = tens, d0 = ones) and the single-pulse beat strobe.
- Drives a 4-digit common-anode seven-segment display by time-multiplexing the digits.
- Adds leading-zero blanking, a "no pulse" stale indication, and frame-synchronous digit capture so the display never tears mid-scan.

Parameters:
REFRESH_DIV, 100000, clk cycles per digit slot (1 kHz slot rate at 100 MHz)
TIMEOUT_CYC, 300000000, cycles without a beat before the display goes stale (3 s)
FLASH_CYC, 10000000, beat-indicator on-time in cycles (100 ms); used only with the optional feature

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset: one clock; rst is asynchronous and active-low
d2  input  4  BCD hundreds digit of bpm
d1  input  4  BCD tens digit of bpm
d0  input  4  BCD ones digit of bpm
beat  input  1  one-cycle strobe per detected pulse (single-pulser output)
an  output  4  digit anodes, active-low; an[i] selects digit slot i
seg  output  7  segments, active-low; seg = {g,f,e,d,c,b,a}
dp  output  1  decimal point, active-low

Behaviour:
- Reset (rst=0, asynchronous, takes effect immediately, including mid-scan):
  - an=4'b1111, seg=7'b1111111, dp=1.
  - Prescaler=0, idx=0, shadow digits=0, timeout count=0, stale=1, flash count=0.
  - The display therefore shows dashes until the first beat arrives.
- Prescaler: counts 0..REFRESH_DIV-1. tick=1 on the terminal count, then the prescaler wraps to 0.
- Scan index idx (2 bits): advances on tick, 0->1->2->3->0.
  - Shadow registers s2, s1, s0 load d2, d1, d0 on the tick where idx wraps 3->0.
  - Inputs are sampled only at that point.
- Outputs are registered. an/seg/dp reflect the new idx one cycle after the tick.
  - Exactly one an bit is low per slot, except slot 3, which is handled under Optional Feature.
- Slot mapping: idx0 -> s0, idx1 -> s1, idx2 -> s2, idx3 -> status slot.
- Decode (active-low patterns):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - any value 10-15 = "E" = 0000110
  - dash = 0111111, blank = 1111111
- Leading-zero blanking (only when stale=0):
  - Slot 2 is blank if s2==0.
  - Slot 1 is blank if s2==0 && s1==0.
  - Slot 0 is always displayed (bpm 0 shows "0").
- Stale tracking:
  - The timeout counter increments every cycle and saturates at TIMEOUT_CYC.
  - On reaching TIMEOUT_CYC, stale=1.
  - beat clears the counter to 0 and sets stale=0 on the next edge.
  - If beat coincides with the saturation cycle, beat wins (stale stays 0).
- While stale=1:
  - Slots 0-2 show dash regardless of the shadow digits.
  - Blanking is disabled.
  - Shadow loading continues normally.
- Transition timing: a stale change is visible from the next slot boundary. The current slot keeps its registered value until the next tick.
- dp is 1 in slots 0-2 at all times.
- Width rule: prescaler and timeout counters are sized with $clog2 of their parameter. The design must be correct for REFRESH_DIV >= 2.

Optional Feature:
PM_BEAT_FLASH_EN
- Defined:
  - beat loads the flash counter with FLASH_CYC. It decrements to 0 each cycle; a beat while it is nonzero reloads it.
  - In slot 3, an[3]=0, seg=blank, and dp=0 while the flash counter is nonzero; otherwise dp=1 and an[3]=1.
  - The stale state does not suppress the flash.
- Not defined:
  - The flash counter is absent.
  - In slot 3, an=4'b1111 and dp=1 for the whole slot (dark slot, duty cycle unchanged).

Test Plan (bench parameters REFRESH_DIV=4, TIMEOUT_CYC=50, FLASH_CYC=8):
1. Reset release, no beat -> an cycles 1110, 1101, 1011, (1111) every 4 clks; seg=0111111 in slots 0-2; dp=1.
2. beat once, then d2=1, d1=2, d0=0 held across a frame wrap -> slot0 seg=1000000, slot1 0100100, slot2 1111001.
3. d2=0, d1=0, d0=7 after beat -> slot0 1111000; slots 1 and 2 blank (1111111) with their anodes still low.
4. Last beat then 50 idle clks -> dashes from the next slot boundary. Then beat on the same cycle the count hits 50 -> stale stays 0.
5. d0 changes from 7 to 5 while idx=1 -> slot0 keeps showing 7 until the 3->0 wrap, then shows 0010010. d0=12 -> "E" (0000110).
6. Assert rst mid-slot 2 -> an=1111 and seg=1111111 immediately, without waiting for a clock edge. With PM_BEAT_FLASH_EN: beat -> dp=0 in slot 3 for slot-3 windows within the 8 clks, dp=1 thereafter.
